// File: rtl/parking_pkg.sv
// Shared definitions for the parking occupancy controller.
//   CNT_W            width of the occupancy count and add/sub operands
//   DEFAULT_CAPACITY default maximum occupancy (legal range 1..7)
//   state_t          gate arbitration FSM states
package parking_pkg;

  localparam int CNT_W            = 3;
  localparam int DEFAULT_CAPACITY = 7;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_OPEN = 2'd1,
    EXIT_OPEN  = 2'd2
  } state_t;

endpackage

// File: rtl/sensor_debounce.sv
// Vehicle sensor conditioner: 2-flop synchroniser, debounce counter and
// rising-edge detector on the debounced level.
//   clk     system clock
//   reset   asynchronous, active-high
//   sensor  raw asynchronous loop sensor
//   req     one-cycle pulse when the debounced level rises
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor,
  output logic req
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // cnt counts consecutive synced samples that differ from the accepted
  // level; the level flips on the DEBOUNCE_CYCLES-th such sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      req   <= 1'b0;
    end else begin
      sync1 <= sensor;
      sync2 <= sync1;
      req   <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        req   <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_occupancy_controller.sv
// Parking counter front end: debounces entry/exit sensors, arbitrates one
// gate at a time, drives the external 3-bit add/sub stage and registers its
// result as the occupancy count.
//   clk, reset          clock; asynchronous active-high reset
//   entry_sensor        raw entry loop sensor
//   exit_sensor         raw exit loop sensor
//   as_sum              add/sub result: [2:0] value, [3] carry (unused)
//   as_s, as_a, as_b    add/sub select (1 = subtract), operand A (= count), operand B (= 1)
//   count               registered occupancy
//   entry_gate          entry gate open
//   exit_gate           exit gate open
//   full, empty         count == CAPACITY / count == 0
//   entry_reject        one-cycle pulse: entry requested while full
module parking_occupancy_controller
  import parking_pkg::*;
#(
  parameter int CAPACITY        = DEFAULT_CAPACITY,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GATE_CYCLES     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_sensor,
  input  logic             exit_sensor,
  input  logic [CNT_W:0]   as_sum,
  output logic             as_s,
  output logic [CNT_W-1:0] as_a,
  output logic [CNT_W-1:0] as_b,
  output logic [CNT_W-1:0] count,
  output logic             entry_gate,
  output logic             exit_gate,
  output logic             full,
  output logic             empty,
  output logic             entry_reject
);

  localparam int TMR_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] gate_tmr;
  logic             gate_done;
  logic             req_in, req_out;
  logic             pend_in, pend_out;
  logic             want_in, want_out;
  logic             serve_in, serve_out;
  logic             reject, drop_out;
  logic             unused_carry;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_deb (
    .clk    (clk),
    .reset  (reset),
    .sensor (entry_sensor),
    .req    (req_in)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_deb (
    .clk    (clk),
    .reset  (reset),
    .sensor (exit_sensor),
    .req    (req_out)
  );

  assign unused_carry = as_sum[CNT_W];
  assign as_a         = count;
  assign as_b         = CNT_W'(1);
  assign full         = (count == CNT_W'(CAPACITY));
  assign empty        = (count == '0);
  assign gate_done    = (gate_tmr == TMR_LAST);

  // A fresh request is folded into the pending flag here so an idle FSM
  // serves it on the very edge the flag would otherwise be set.
  assign want_in  = pend_in  | req_in;
  assign want_out = pend_out | req_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    serve_in  = 1'b0;
    serve_out = 1'b0;
    reject    = 1'b0;
    drop_out  = 1'b0;
    case (state)
      IDLE: begin
        // Exit first: it frees a space for a waiting entry.
        if (want_out && !empty) begin
          serve_out = 1'b1;
          state_nxt = EXIT_OPEN;
        end else begin
          drop_out = want_out;
          if (want_in && !full) begin
            serve_in  = 1'b1;
            state_nxt = ENTRY_OPEN;
          end else begin
            reject = want_in;
          end
        end
      end
      ENTRY_OPEN, EXIT_OPEN: if (gate_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    entry_gate   = (state == ENTRY_OPEN);
    exit_gate    = (state == EXIT_OPEN);
    as_s         = serve_out;
    entry_reject = reject;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      pend_in  <= 1'b0;
      pend_out <= 1'b0;
      gate_tmr <= '0;
    end else begin
      if (serve_in || serve_out) count <= as_sum[CNT_W-1:0];
      pend_in  <= (serve_in  || reject)   ? 1'b0 : want_in;
      pend_out <= (serve_out || drop_out) ? 1'b0 : want_out;
      gate_tmr <= (state != IDLE && !gate_done) ? gate_tmr + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_parking_occupancy_controller.sv
// Self-checking bench for parking_occupancy_controller: directed scenarios
// with literal expectations plus randomized sensor traffic, all compared
// every cycle against a behavioural occupancy model.
module tb_parking_occupancy_controller;

  localparam int CAP = 7;
  localparam int D   = 4;
  localparam int G   = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       entry_sensor = 1'b0;
  logic       exit_sensor = 1'b0;
  logic [3:0] as_sum;
  logic       as_s;
  logic [2:0] as_a, as_b, count;
  logic       entry_gate, exit_gate, full, empty, entry_reject;

  int n_cmp = 0;
  int n_err = 0;

  parking_occupancy_controller #(
    .CAPACITY        (CAP),
    .DEBOUNCE_CYCLES (D),
    .GATE_CYCLES     (G)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .entry_sensor (entry_sensor),
    .exit_sensor  (exit_sensor),
    .as_sum       (as_sum),
    .as_s         (as_s),
    .as_a         (as_a),
    .as_b         (as_b),
    .count        (count),
    .entry_gate   (entry_gate),
    .exit_gate    (exit_gate),
    .full         (full),
    .empty        (empty),
    .entry_reject (entry_reject)
  );

  // External add/sub stage: subtract is A + ~B + 1, carry = no-borrow.
  assign as_sum = as_s ? ({1'b0, as_a} + {1'b0, ~as_b} + 4'd1)
                       : ({1'b0, as_a} + {1'b0, as_b});

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Sensor index 0 = entry, 1 = exit. m_gate: 0 none, 1 entry, 2 exit.
  int m_count = 0;
  int m_gate  = 0;
  int m_left  = 0;
  bit mpend [2];
  bit mreq  [2];
  bit lvl   [2];
  bit rq    [2][2];
  bit hist  [2][D];

  always @(posedge clk or posedge reset) begin : model
    bit ein, eout, synced, same;
    if (reset) begin
      m_count = 0; m_gate = 0; m_left = 0;
      for (int s = 0; s < 2; s++) begin
        mpend[s] = 0; mreq[s] = 0; lvl[s] = 0; rq[s][0] = 0; rq[s][1] = 0;
        for (int k = 0; k < D; k++) hist[s][k] = 0;
      end
    end else begin
      ein  = mpend[0] | mreq[0];
      eout = mpend[1] | mreq[1];
      if (m_gate != 0) begin
        m_left = m_left - 1;
        if (m_left == 0) m_gate = 0;
        mpend[0] = ein;
        mpend[1] = eout;
      end else if (eout && m_count > 0) begin
        m_count  = m_count - 1;
        m_gate   = 2; m_left = G;
        mpend[1] = 0;
        mpend[0] = ein;
      end else begin
        mpend[1] = 0;
        if (ein && m_count < CAP) begin
          m_count = m_count + 1;
          m_gate  = 1; m_left = G;
        end
        mpend[0] = 0;
      end
      // A level is accepted once the last D synced samples all agree on it.
      for (int s = 0; s < 2; s++) begin
        synced   = rq[s][1];
        rq[s][1] = rq[s][0];
        rq[s][0] = (s == 0) ? entry_sensor : exit_sensor;
        for (int k = D - 1; k > 0; k--) hist[s][k] = hist[s][k-1];
        hist[s][0] = synced;
        same = 1;
        for (int k = 0; k < D; k++) if (hist[s][k] != synced) same = 0;
        mreq[s] = 0;
        if (same && synced != lvl[s]) begin
          lvl[s]  = synced;
          mreq[s] = synced;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    bit ein, eout, e_s, e_rej;
    ein   = mpend[0] | mreq[0];
    eout  = mpend[1] | mreq[1];
    e_s   = (m_gate == 0) && eout && (m_count > 0);
    e_rej = (m_gate == 0) && ein && !e_s && (m_count == CAP);
    check("cyc_count",        int'(count),        m_count);
    check("cyc_as_a",         int'(as_a),         m_count);
    check("cyc_as_b",         int'(as_b),         1);
    check("cyc_full",         int'(full),         int'(m_count == CAP));
    check("cyc_empty",        int'(empty),        int'(m_count == 0));
    check("cyc_entry_gate",   int'(entry_gate),   int'(m_gate == 1));
    check("cyc_exit_gate",    int'(exit_gate),    int'(m_gate == 2));
    check("cyc_as_s",         int'(as_s),         int'(e_s));
    check("cyc_entry_reject", int'(entry_reject), int'(e_rej));
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  // One vehicle on sensor s; returns how many cycles saw reject / each gate.
  task automatic car(input int s, output int rej, output int eg, output int xg);
    rej = 0; eg = 0; xg = 0;
    if (s == 0) entry_sensor = 1'b1; else exit_sensor = 1'b1;
    for (int i = 0; i < 28; i++) begin
      if (i == 8) begin entry_sensor = 1'b0; exit_sensor = 1'b0; end
      step(1);
      rej += int'(entry_reject);
      eg  += int'(entry_gate);
      xg  += int'(exit_gate);
    end
  endtask

  int rej, eg, xg, glen, gate_seen, first_gate, cnt_at_exit, cnt_at_entry, overlap;
  bit opened;

  initial begin
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(2);
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full",  int'(full), 0);
    check("rst_gates", int'(entry_gate | exit_gate), 0);
    check("rst_as_s",  int'(as_s), 0);

    // 1: long entry pulse, latency D+3 edges, gate open G cycles.
    entry_sensor = 1'b1;
    step(6);
    check("lat_edge6_gate", int'(entry_gate), 0);
    step(1);
    check("lat_edge7_gate",  int'(entry_gate), 1);
    check("lat_edge7_count", int'(count), 1);
    glen = 1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      glen += int'(entry_gate);
    end
    check("gate_len", glen, 8);
    step(1);
    entry_sensor = 1'b0;
    step(12);
    check("held_one_req_count", int'(count), 1);

    // 2: short glitch produces no request.
    do_reset();
    entry_sensor = 1'b1;
    step(3);
    entry_sensor = 1'b0;
    gate_seen = 0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      gate_seen += int'(entry_gate | exit_gate);
    end
    check("glitch_gates", gate_seen, 0);
    check("glitch_count", int'(count), 0);

    // 3: fill to capacity, then one rejected entry.
    for (int i = 0; i < 6; i++) car(0, rej, eg, xg);
    check("fill6_count", int'(count), 6);
    check("fill6_full",  int'(full), 0);
    car(0, rej, eg, xg);
    check("fill7_count", int'(count), 7);
    check("fill7_full",  int'(full), 1);
    car(0, rej, eg, xg);
    check("over_reject_pulses", rej, 1);
    check("over_entry_gate",    eg, 0);
    check("over_count",         int'(count), 7);

    // 4: simultaneous entry and exit at count 3.
    for (int i = 0; i < 4; i++) car(1, rej, eg, xg);
    check("drain_count", int'(count), 3);
    entry_sensor = 1'b1;
    exit_sensor  = 1'b1;
    first_gate = 0; cnt_at_exit = -1; cnt_at_entry = -1; overlap = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 8) begin entry_sensor = 1'b0; exit_sensor = 1'b0; end
      step(1);
      if (entry_gate && exit_gate) overlap++;
      if (first_gate == 0 && exit_gate)  first_gate = 2;
      if (first_gate == 0 && entry_gate) first_gate = 1;
      if (exit_gate  && cnt_at_exit  < 0) cnt_at_exit  = int'(count);
      if (entry_gate && cnt_at_entry < 0) cnt_at_entry = int'(count);
    end
    check("both_first_gate",   first_gate, 2);
    check("both_exit_count",   cnt_at_exit, 2);
    check("both_entry_count",  cnt_at_entry, 3);
    check("both_overlap",      overlap, 0);
    check("both_final_count",  int'(count), 3);

    // 5: spurious exit at empty is dropped, and stays dropped.
    do_reset();
    car(1, rej, eg, xg);
    check("spur_exit_gate", xg, 0);
    check("spur_count",     int'(count), 0);
    car(0, rej, eg, xg);
    check("spur_then_entry_gate", eg, 8);
    check("spur_then_exit_gate",  xg, 0);
    check("spur_then_count",      int'(count), 1);

    // 6: asynchronous reset while an entry gate is open.
    do_reset();
    entry_sensor = 1'b1;
    opened = 0;
    for (int i = 0; i < 12 && !opened; i++) begin
      step(1);
      opened = entry_gate;
    end
    check("mid_gate_opened", int'(opened), 1);
    step(3);
    reset = 1'b1;
    #1;
    check("async_entry_gate", int'(entry_gate), 0);
    check("async_count",      int'(count), 0);
    check("async_empty",      int'(empty), 1);
    step(2);
    entry_sensor = 1'b0;
    reset = 1'b0;
    step(1);
    car(0, rej, eg, xg);
    check("post_reset_count", int'(count), 1);

    // Randomized traffic, checked every cycle by the compare process.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) entry_sensor = ~entry_sensor;
      if ($urandom_range(0, 9) == 0) exit_sensor  = ~exit_sensor;
      reset = ($urandom_range(0, 599) == 0);
      step(1);
    end
    reset = 1'b0;
    entry_sensor = 1'b0;
    exit_sensor  = 1'b0;
    step(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
